// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-side load/store unit: access-size codes,
// FSM state encodings and per-mode size/lane helpers.
package data_mem_ctrl_pkg;

  localparam logic [1:0] MEM_BYTE    = 2'b00;
  localparam logic [1:0] MEM_HALF    = 2'b01;
  localparam logic [1:0] MEM_WORD    = 2'b10;
  localparam logic [1:0] MEM_INVALID = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_LO   = 3'd2,
    ST_RD_HI   = 3'd3,
    ST_WR_HI   = 3'd4
  } state_t;

  // Access size in bytes; the invalid code is filtered out before this matters.
  function automatic logic [2:0] mode_size(input logic [1:0] mode);
    case (mode)
      MEM_BYTE: mode_size = SIZE_BYTE;
      MEM_HALF: mode_size = SIZE_HALF;
      default:  mode_size = SIZE_WORD;
    endcase
  endfunction

  // Right-aligned lane mask covering the access size.
  function automatic logic [3:0] mode_lanes(input logic [1:0] mode);
    case (mode)
      MEM_BYTE: mode_lanes = 4'b0001;
      MEM_HALF: mode_lanes = 4'b0011;
      MEM_WORD: mode_lanes = 4'b1111;
      default:  mode_lanes = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// Byte select and sign/zero extension of load data taken from a 64-bit
// window (two consecutive SRAM words, low word in bits 31:0).
module load_extend
  import data_mem_ctrl_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [1:0]  mode,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [5:0]  bit_offset;
  logic [31:0] picked;

  assign bit_offset = {1'b0, offset, 3'b000};
  assign picked     = window[bit_offset +: 32];

  // Truncate to the access size and extend from its top bit unless unsigned.
  always_comb begin
    result = picked;
    case (mode)
      MEM_BYTE: result = {{24{~is_unsigned & picked[7]}}, picked[7:0]};
      MEM_HALF: result = {{16{~is_unsigned & picked[15]}}, picked[15:0]};
      default:  result = picked;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side load/store unit: drives a word-wide synchronous SRAM with lane
// alignment, splits misaligned accesses over two words and stalls the
// pipeline while multi-cycle accesses are in flight.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_read,
  input  logic                       req_write,
  input  logic [1:0]                 mem_mode,
  input  logic                       mem_unsigned,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       stall,
  output logic                       err,
  output logic                       sram_en,
  output logic                       sram_we,
  output logic [WORD_ADDR_WIDTH-1:0] sram_addr,
  output logic [3:0]                 sram_be,
  output logic [31:0]                sram_wdata,
  input  logic [31:0]                sram_rdata
);

  state_t      state_reg, state_next;
  logic [31:0] hold_reg, hold_next;

  logic [1:0]                 offset;
  logic [WORD_ADDR_WIDTH-1:0] word_a;
  logic [WORD_ADDR_WIDTH-1:0] word_b;
  logic [3:0]                 end_byte;
  logic                       misaligned;
  logic                       invalid;
  logic [7:0]                 lanes_wide;
  logic [63:0]                data_wide;
  logic [63:0]                read_window;
  logic [31:0]                load_value;
  logic                       unused_addr;

  assign offset      = addr[1:0];
  assign word_a      = addr[WORD_ADDR_WIDTH+1:2];
  // Natural overflow of the word-address width gives the wrap to word 0.
  assign word_b      = word_a + 1'b1;
  assign unused_addr = ^addr[31:WORD_ADDR_WIDTH+2];

  assign end_byte   = {2'b00, offset} + {1'b0, mode_size(mem_mode)};
  assign misaligned = end_byte > 4'd4;
  assign invalid    = (req_read & req_write) |
                      ((req_read | req_write) & (mem_mode == MEM_INVALID));

  // Lanes and data shifted across an 8-lane span: the low half is word A,
  // the high half is what spills into word A+1.
  assign lanes_wide = {4'b0000, mode_lanes(mem_mode)} << offset;
  assign data_wide  = {32'd0, wdata} << {offset, 3'b000};

  assign read_window = (state_reg == ST_RD_HI) ? {sram_rdata, hold_reg}
                                               : {32'd0, sram_rdata};

  load_extend u_load_extend (
    .window      (read_window),
    .offset      (offset),
    .mode        (mem_mode),
    .is_unsigned (mem_unsigned),
    .result      (load_value)
  );

  // State and holding register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      hold_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // Next-state and all outputs; everything stays quiet while reset is high.
  always_comb begin
    state_next = ST_IDLE;
    hold_next  = hold_reg;
    rdata      = 32'd0;
    stall      = 1'b0;
    err        = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_be    = 4'b0000;
    sram_wdata = 32'd0;
    if (!reset) begin
      case (state_reg)
        ST_IDLE: begin
          if (invalid) begin
            err = 1'b1;
          end else if (req_write) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = word_a;
            sram_be    = lanes_wide[3:0];
            sram_wdata = data_wide[31:0];
            if (misaligned) begin
              stall      = 1'b1;
              state_next = ST_WR_HI;
            end
          end else if (req_read) begin
            sram_en    = 1'b1;
            sram_addr  = word_a;
            stall      = 1'b1;
            state_next = misaligned ? ST_RD_LO : ST_RD_WAIT;
          end
        end
        ST_WR_HI: begin
          sram_en    = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = word_b;
          sram_be    = lanes_wide[7:4];
          sram_wdata = data_wide[63:32];
        end
        ST_RD_WAIT: begin
          rdata = load_value;
        end
        ST_RD_LO: begin
          hold_next  = sram_rdata;
          sram_en    = 1'b1;
          sram_addr  = word_b;
          stall      = 1'b1;
          state_next = ST_RD_HI;
        end
        ST_RD_HI: begin
          rdata = load_value;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a byte-addressed golden memory
// predicts load results and stall counts; directed cases cover the split,
// wrap, invalid and reset behaviour, followed by random traffic.
module tb_data_mem_ctrl;

  localparam int W     = 10;
  localparam int BYTES = 4 << W;

  logic          clk;
  logic          reset;
  logic          req_read;
  logic          req_write;
  logic [1:0]    mem_mode;
  logic          mem_unsigned;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          stall;
  logic          err;
  logic          sram_en;
  logic          sram_we;
  logic [W-1:0]  sram_addr;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  logic [31:0] sram_mem [1 << W];
  logic [7:0]  gmem [BYTES];

  int checks   = 0;
  int failures = 0;

  data_mem_ctrl #(.WORD_ADDR_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_read     (req_read),
    .req_write    (req_write),
    .mem_mode     (mem_mode),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .err          (err),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_be      (sram_be),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM with byte-lane writes and one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] mode);
    return (mode == 2'b00) ? 1 : (mode == 2'b01) ? 2 : 4;
  endfunction

  function automatic void model_write(input logic [1:0] mode, input logic [31:0] a,
                                      input logic [31:0] d);
    for (int i = 0; i < size_of(mode); i++)
      gmem[(a + i) & (BYTES - 1)] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] mode, input logic uns,
                                             input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < size_of(mode); i++)
      v[8*i +: 8] = gmem[(a + i) & (BYTES - 1)];
    if (!uns && mode == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uns && mode == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic idle_inputs();
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  // One access: drive, wait for the completion cycle, check stalls and data.
  task automatic do_access(input logic wr, input logic [1:0] mode, input logic uns,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] got);
    int          stalls;
    int          exp_stalls;
    int          n;
    bit          done;
    logic [31:0] exp;
    n          = size_of(mode);
    exp_stalls = (int'(a[1:0]) + n > 4) ? (wr ? 1 : 2) : (wr ? 0 : 1);
    exp        = wr ? 32'd0 : model_load(mode, uns, a);
    @(negedge clk);
    req_read = !wr; req_write = wr; mem_mode = mode; mem_unsigned = uns;
    addr = a; wdata = d;
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 8 && !done; c++) begin
      #1;
      if (!stall) done = 1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    got = rdata;
    if (!done) check("timeout", 32'd1, 32'd0);
    $display("%s mode=%0d uns=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h stalls=%0d",
             wr ? "ST" : "LD", mode, uns, a, d, rdata, stalls);
    check(wr ? "st_stalls" : "ld_stalls", stalls, exp_stalls);
    check(wr ? "st_rdata" : "ld_rdata", rdata, exp);
    check("access_err", {31'd0, err}, 32'd0);
    if (wr) model_write(mode, a, d);
    @(negedge clk);
    idle_inputs();
    #1;
    check("idle_en", {31'd0, sram_en}, 32'd0);
  endtask

  // Two-cycle misaligned store with explicit per-cycle SRAM port checks.
  task automatic split_store(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] d1);
    @(negedge clk);
    req_write = 1'b1; req_read = 1'b0; mem_mode = mode; mem_unsigned = 1'b0;
    addr = a; wdata = d;
    #1;
    $display("SPLIT-ST c0 addr=%0d be=%b data=0x%08h stall=%0d", sram_addr, sram_be, sram_wdata, stall);
    check("split0_addr", {22'd0, sram_addr}, a0);
    check("split0_be", {28'd0, sram_be}, {28'd0, be0});
    check("split0_data", sram_wdata, d0);
    check("split0_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1;
    $display("SPLIT-ST c1 addr=%0d be=%b data=0x%08h stall=%0d", sram_addr, sram_be, sram_wdata, stall);
    check("split1_addr", {22'd0, sram_addr}, a1);
    check("split1_be", {28'd0, sram_be}, {28'd0, be1});
    check("split1_data", sram_wdata, d1);
    check("split1_stall", {31'd0, stall}, 32'd0);
    model_write(mode, a, d);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [1:0]  mode;
    logic        wr;

    for (int i = 0; i < (1 << W); i++) sram_mem[i] = 32'd0;
    for (int i = 0; i < BYTES; i++) gmem[i] = 8'd0;
    sram_rdata = 32'd0;
    reset = 1'b1; mem_mode = 2'b00; mem_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0;
    req_read = 1'b1; req_write = 1'b0;

    // Reset state: outputs quiet even with a request on the inputs.
    repeat (2) @(negedge clk);
    #1;
    $display("RESET stall=%0d rdata=0x%08h err=%0d en=%0d", stall, rdata, err, sram_en);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_en", {31'd0, sram_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("idle_stall", {31'd0, stall}, 32'd0);

    // Aligned word store: single cycle, all lanes, word 4.
    @(negedge clk);
    req_write = 1'b1; mem_mode = 2'b10; addr = 32'h10; wdata = 32'hDEADBEEF;
    #1;
    $display("SW addr=0x10 be=%b word=%0d stall=%0d", sram_be, sram_addr, stall);
    check("sw_be", {28'd0, sram_be}, 32'hF);
    check("sw_addr", {22'd0, sram_addr}, 32'd4);
    check("sw_stall", {31'd0, stall}, 32'd0);
    check("sw_data", sram_wdata, 32'hDEADBEEF);
    model_write(2'b10, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, got);
    check("lw_const", got, 32'hDEADBEEF);

    // Extension of bytes and halves.
    do_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h800180FF, got);
    do_access(1'b0, 2'b00, 1'b0, 32'h20, 32'd0, got);
    check("lb_const", got, 32'hFFFFFFFF);
    do_access(1'b0, 2'b00, 1'b1, 32'h20, 32'd0, got);
    check("lbu_const", got, 32'h000000FF);
    do_access(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, got);
    check("lh_const", got, 32'hFFFF8001);
    do_access(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, got);
    check("lhu_const", got, 32'h00008001);

    // Misaligned word store and reload.
    split_store(2'b10, 32'h13, 32'h11223344,
                32'd4, 4'b1000, 32'h44000000, 32'd5, 4'b0111, 32'h00112233);
    do_access(1'b0, 2'b10, 1'b0, 32'h13, 32'd0, got);
    check("lw_split_const", got, 32'h11223344);

    // Half store straddling the last word wraps to word 0.
    split_store(2'b01, BYTES - 1, 32'h0000ABCD,
                (1 << W) - 1, 4'b1000, 32'hCD000000, 32'd0, 4'b0001, 32'h000000AB);
    do_access(1'b0, 2'b01, 1'b1, BYTES - 1, 32'd0, got);
    check("lhu_wrap_const", got, 32'h0000ABCD);

    // Invalid requests: err pulse, no access, no stall.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_read = 1'b1; req_write = (k == 1); mem_mode = (k == 0) ? 2'b11 : 2'b10;
      addr = 32'h40;
      #1;
      $display("INVALID case=%0d err=%0d en=%0d stall=%0d", k, err, sram_en, stall);
      check("inv_err", {31'd0, err}, 32'd1);
      check("inv_en", {31'd0, sram_en}, 32'd0);
      check("inv_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("inv_err_clear", {31'd0, err}, 32'd0);
    end

    // Reset during WR_HI drops the second write.
    @(negedge clk);
    req_write = 1'b1; mem_mode = 2'b10; addr = 32'h21; wdata = 32'hA1B2C3D4;
    #1;
    check("rstwr_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) gmem[32'h21 + i] = wdata[8*i +: 8];
    @(negedge clk);
    reset = 1'b1;
    #1;
    $display("RESET-IN-WR_HI en=%0d stall=%0d err=%0d rdata=0x%08h", sram_en, stall, err, rdata);
    check("rstwr_en", {31'd0, sram_en}, 32'd0);
    check("rstwr_stall0", {31'd0, stall}, 32'd0);
    check("rstwr_err", {31'd0, err}, 32'd0);
    check("rstwr_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rstwr_idle_en", {31'd0, sram_en}, 32'd0);
    check("rstwr_idle_stall", {31'd0, stall}, 32'd0);
    do_access(1'b0, 2'b10, 1'b0, 32'h24, 32'd0, got);
    do_access(1'b0, 2'b00, 1'b0, 32'h21, 32'd0, got);
    check("rstwr_lb_const", got, 32'hFFFFFFD4);

    // Random traffic against the golden byte memory.
    for (int t = 0; t < 200; t++) begin
      wr   = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) a = BYTES - $urandom_range(1, 12);
      else a = $urandom_range(0, 63);
      a = {$urandom() & 32'hFFFF_F000} | (a & (BYTES - 1));
      do_access(wr, mode, 1'($urandom_range(0, 1)), a, $urandom(), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
